gbus_burst_master: RTL and testbench

- Global-bus initiator for one head row of the core array. It converts burst commands into per-cycle gbus write and read strobes toward VNUM cores.
- Write bursts stream payload from an upstream valid/ready source into core memories.
- Read bursts collect gbus_rdata/gbus_rvalid responses into a small FIFO and deliver them downstream over valid/ready with credit-based flow control.

---
 rtl/gbus_master_pkg.sv | 10 +
 rtl/gbus_rsp_fifo.sv | 33 +++
 rtl/gbus_burst_master.sv | 125 ++++++++++++
 tb/tb_gbus_burst_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbus_master_pkg.sv
// gbus_master_pkg: shared state, opcode and width helpers for the gbus burst master.
package gbus_master_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;
  localparam int PERF_W = 32;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/gbus_rsp_fifo.sv
// gbus_rsp_fifo: show-ahead response FIFO; dout reads 0 while empty.
module gbus_rsp_fifo
  import gbus_master_pkg::*;
#(
  parameter int W = 64,
  parameter int DEPTH = 4,
  parameter int CW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout = (count != '0) ? mem[rp] : '0;
endmodule

// File: rtl/gbus_burst_master.sv
// gbus_burst_master: burst command to gbus strobe engine; GBUS_MASTER_PERF_EN adds perf counters.
module gbus_burst_master
  import gbus_master_pkg::*;
#(
  parameter int VNUM = 8,
  parameter int GBUS_DATA = 64,
  parameter int GBUS_ADDR = 12,
  parameter int LEN_BIT = 8,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [VNUM-1:0]      cmd_core_mask,
  input  logic [GBUS_ADDR-1:0] cmd_addr,
  input  logic [LEN_BIT-1:0]   cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [GBUS_DATA-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [GBUS_DATA-1:0] rd_data,
  output logic [GBUS_ADDR-1:0] gbus_addr,
  output logic [VNUM-1:0]      gbus_wen,
  output logic [GBUS_DATA-1:0] gbus_wdata,
  output logic [VNUM-1:0]      gbus_ren,
  input  logic [GBUS_DATA-1:0] gbus_rdata,
  input  logic [VNUM-1:0]      gbus_rvalid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef GBUS_MASTER_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_beats,
  output logic [PERF_W-1:0]    perf_stall
`endif
);
  localparam int CW = cnt_w(RFIFO_DEPTH);
  state_t state, state_nx;
  logic [VNUM-1:0] mask;
  logic [GBUS_ADDR-1:0] addr;
  logic [LEN_BIT-1:0] cnt;
  logic [CW-1:0] outst, fcount;
  logic accept, cmd_ok, wbeat, issue, rsp, rsp_ok, last, pop;
  assign cmd_ready = (state == IDLE) && !rst;
  assign wr_ready = state == WRITE;
  assign busy = state != IDLE;
  assign rd_valid = fcount != '0;
  assign pop = rd_valid && rd_ready;
  always_comb begin
    accept = cmd_valid && cmd_ready;
    cmd_ok = (cmd_len != '0) && !(cmd_op == OP_RD && !$onehot(cmd_core_mask));
    wbeat = wr_valid && wr_ready;
    // credit: every issued read owns a FIFO slot until it is popped
    issue = (state == READ) && (({1'b0, outst} + {1'b0, fcount}) < (CW+1)'(RFIFO_DEPTH));
    rsp = |(gbus_rvalid & mask);
    rsp_ok = rsp && (outst != '0);
    last = cnt == LEN_BIT'(1);
    state_nx = state;
    case (state)
      IDLE:    if (accept && cmd_ok) state_nx = (cmd_op == OP_RD) ? READ : WRITE;
      WRITE:   if (wbeat && last) state_nx = IDLE;
      READ:    if (issue && last) state_nx = DRAIN;
      DRAIN:   if (outst == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask <= '0;
      addr <= '0;
      cnt <= '0;
      outst <= '0;
      gbus_addr <= '0;
      gbus_wen <= '0;
      gbus_wdata <= '0;
      gbus_ren <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      gbus_wen <= wbeat ? mask : '0;
      gbus_ren <= issue ? mask : '0;
      done <= (accept && cmd_len == '0) || (wbeat && last) || (state == DRAIN && outst == '0);
      err <= (rsp && !rsp_ok) || (accept && cmd_len != '0 && cmd_op == OP_RD && !$onehot(cmd_core_mask));
      outst <= outst + CW'(issue) - CW'(rsp_ok);
      if (accept) begin
        mask <= cmd_core_mask;
        addr <= cmd_addr;
        cnt <= cmd_len;
      end
      if (wbeat || issue) begin
        gbus_addr <= addr;
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
      end
      if (wbeat) gbus_wdata <= wr_data;
    end
  gbus_rsp_fifo #(.W(GBUS_DATA), .DEPTH(RFIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rsp_ok),
    .pop(pop),
    .din(gbus_rdata),
    .dout(rd_data),
    .count(fcount)
  );
`ifdef GBUS_MASTER_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else if (accept) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if ((wbeat || issue) && perf_beats != '1) perf_beats <= perf_beats + 1'b1;
      if ((state == WRITE || state == READ) && !(wbeat || issue) && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
`endif
endmodule

// File: tb/tb_gbus_burst_master.sv
// tb_gbus_burst_master: randomized scenario bench with a behavioural core and stream model.
module tb_gbus_burst_master;
  localparam int DEP = 4;
  logic clk, rst, cmd_valid, cmd_ready, cmd_op, wr_valid, wr_ready, rd_valid, rd_ready;
  logic busy, done, err;
  logic [7:0] cmd_core_mask, gbus_wen, gbus_ren, gbus_rvalid;
  logic [11:0] cmd_addr, gbus_addr;
  logic [7:0] cmd_len;
  logic [63:0] wr_data, rd_data, gbus_wdata, gbus_rdata;
`ifdef GBUS_MASTER_PERF_EN
  logic [31:0] perf_beats, perf_stall;
`endif
  int checks = 0, errors = 0;
  int cyc = 0, tot_iss = 0, tot_pop = 0, done_cnt = 0, done_cyc = 0, last_rsp = 0;
  logic hs_w;
  bit core_en = 0;
  logic [7:0] core_mask = '0;
  int due_q[$];
  logic [63:0] dat_q[$], exp_q[$], got_q[$];

  gbus_burst_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_core_mask(cmd_core_mask), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .gbus_addr(gbus_addr), .gbus_wen(gbus_wen), .gbus_wdata(gbus_wdata), .gbus_ren(gbus_ren),
    .gbus_rdata(gbus_rdata), .gbus_rvalid(gbus_rvalid), .busy(busy), .done(done), .err(err)
`ifdef GBUS_MASTER_PERF_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rd_word(input logic [11:0] a);
    return {20'hC0FFE, a, 20'hBA5E0, a};
  endfunction

  // one clock: record handshakes, then emulate the addressed core (fixed 3-cycle read latency)
  task automatic tick();
    @(negedge clk);
    hs_w = wr_valid && wr_ready;
    if (rd_valid && rd_ready) begin
      got_q.push_back(rd_data);
      tot_pop++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (core_en) begin
      if ((gbus_ren & core_mask) != 0) begin
        due_q.push_back(cyc + 3);
        dat_q.push_back(rd_word(gbus_addr));
      end
      gbus_rvalid = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        gbus_rvalid = core_mask;
        gbus_rdata = dat_q.pop_front();
        void'(due_q.pop_front());
        last_rsp = cyc;
      end
    end
  endtask

  task automatic send_cmd(input logic op, input logic [7:0] m, input logic [11:0] a, input logic [7:0] l);
    cmd_valid = 1;
    cmd_op = op;
    cmd_core_mask = m;
    cmd_addr = a;
    cmd_len = l;
    tick();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, busy, done, err, gbus_wen, gbus_ren, gbus_addr, gbus_wdata, rd_data} !== '0)
      begin errors++; $display("FAIL reset_outputs got %h exp 0", {cmd_ready, wr_ready, rd_valid, busy, done, err, gbus_wen, gbus_ren, gbus_addr, gbus_wdata, rd_data}); end
    @(negedge clk);
    rst = 0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle got ready=%b busy=%b exp 1 0", cmd_ready, busy); end
  endtask

  task automatic test_write(input logic [11:0] base, input logic [7:0] m, input int len, input int mode, input bit directed);
    logic [63:0] pay[$];
    logic [63:0] ed;
    logic [11:0] ea;
    logic [7:0] ew;
    int k, n, stalls;
    bit have;
    for (int i = 0; i < len; i++) pay.push_back(directed ? (64'hDEADBEEF_00000000 | 64'(i)) : {$urandom, $urandom});
    send_cmd(0, m, base, 8'(len));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_accept got busy=%b exp 1", busy); end
    k = 0; n = 0; stalls = 0; have = 0; ea = '0; ed = '0;
    while (k < len && n < 200) begin
      wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : ($urandom_range(0, 2) != 0);
      wr_data = pay[k];
      if (!wr_valid) stalls++;
      tick();
      n++;
      ew = hs_w ? m : 8'h00;
      if (hs_w) begin
        ea = base + 12'(k);
        ed = pay[k];
        k++;
        have = 1;
      end
      checks++;
      if (gbus_wen !== ew || gbus_ren !== 8'h00 || done !== (hs_w && k == len) || (have && (gbus_addr !== ea || gbus_wdata !== ed))) begin
        errors++;
        $display("FAIL write_beat got wen=%h addr=%h data=%h done=%b exp wen=%h addr=%h data=%h done=%b",
                 gbus_wen, gbus_addr, gbus_wdata, done, ew, ea, ed, hs_w && k == len);
      end
    end
    wr_valid = 0;
    checks++;
    if (k != len || busy !== 1'b0) begin errors++; $display("FAIL write_end got beats=%0d busy=%b exp %0d 0", k, busy, len); end
`ifdef GBUS_MASTER_PERF_EN
    checks++;
    if (perf_beats !== 32'(len) || perf_stall !== 32'(stalls)) begin
      errors++; $display("FAIL write_perf got %0d/%0d exp %0d/%0d", perf_beats, perf_stall, len, stalls);
    end
`endif
  endtask

  task automatic test_read(input logic [11:0] base, input logic [7:0] m, input int len, input int stall, input bit hold);
    int iss, n, d0;
    logic [63:0] w, e;
    core_en = 1;
    core_mask = m;
    for (int i = 0; i < len; i++) exp_q.push_back(rd_word(base + 12'(i)));
    if (hold || stall > 0) rd_ready = 0;
    d0 = done_cnt;
    send_cmd(1, m, base, 8'(len));
    iss = 0; n = 0;
    while (n < 400 && !(done_cnt > d0 && (hold || exp_q.size() == 0))) begin
      rd_ready = (hold || n < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
      n++;
      if (gbus_ren !== 8'h00) begin
        checks++;
        if (gbus_ren !== m || gbus_addr !== base + 12'(iss)) begin
          errors++; $display("FAIL read_issue got ren=%h addr=%h exp ren=%h addr=%h", gbus_ren, gbus_addr, m, base + 12'(iss));
        end
        iss++;
        tot_iss++;
      end
      while (got_q.size() > 0) begin
        w = got_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~w;
        checks++;
        if (w !== e) begin errors++; $display("FAIL read_data got %h exp %h", w, e); end
      end
      checks++;
      if (tot_iss - tot_pop > DEP) begin errors++; $display("FAIL read_credit got %0d in flight exp <= %0d", tot_iss - tot_pop, DEP); end
      if (stall > 0 && n == stall) begin
        checks++;
        if (iss != ((len < DEP) ? len : DEP) || rd_valid !== 1'b1) begin
          errors++; $display("FAIL read_stall got issued=%0d rd_valid=%b exp %0d 1", iss, rd_valid, (len < DEP) ? len : DEP);
        end
      end
    end
    checks++;
    if (iss != len || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL read_end got issued=%0d dones=%0d busy=%b exp %0d 1 0", iss, done_cnt - d0, busy, len);
    end
    checks++;
    if (done_cyc <= last_rsp || done_cyc > last_rsp + 2) begin
      errors++; $display("FAIL read_done_time got cycle %0d exp just after response cycle %0d", done_cyc, last_rsp);
    end
  endtask

  task automatic test_errors();
    bit quiet;
    send_cmd(1, 8'h03, 12'h100, 8'd4);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_mask got err=%b done=%b busy=%b exp 1 0 0", err, done, busy); end
    quiet = 1;
    repeat (5) begin
      tick();
      if (gbus_ren !== 8'h00 || err !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL bad_mask_quiet got activity exp none"); end
    send_cmd(0, 8'hFF, 12'h120, 8'd0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || gbus_wen !== 8'h00) begin errors++; $display("FAIL wr_len0 got done=%b err=%b wen=%h exp 1 0 00", done, err, gbus_wen); end
    send_cmd(1, 8'h10, 12'h140, 8'd0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_len0 got done=%b err=%b busy=%b exp 1 0 0", done, err, busy); end
    quiet = 1;
    repeat (4) begin
      tick();
      if (gbus_ren !== 8'h00 || gbus_wen !== 8'h00 || done !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet || cmd_ready !== 1'b1) begin errors++; $display("FAIL len0_quiet got ready=%b quiet=%b exp 1 1", cmd_ready, quiet); end
  endtask

  task automatic test_spurious();
    core_en = 0;
    gbus_rvalid = 8'h10;
    gbus_rdata = {$urandom, $urandom};
    tick();
    gbus_rvalid = '0;
    checks++;
    if (err !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL spurious got err=%b rd_valid=%b exp 1 0", err, rd_valid); end
    tick();
    checks++;
    if (err !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL spurious_after got err=%b rd_valid=%b exp 0 0", err, rd_valid); end
  endtask

  task automatic test_back_to_back();
    test_read(12'h300, 8'h01, 3, 0, 1);
    checks++;
    if (rd_valid !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_held got rd_valid=%b ready=%b exp 1 1", rd_valid, cmd_ready); end
    test_read(12'h400, 8'h01, 5, 0, 0);
  endtask

  task automatic test_random();
    repeat (8) begin
      if ($urandom_range(0, 1) == 0)
        test_write(12'($urandom), 8'($urandom_range(1, 255)), $urandom_range(1, 12), 2, 0);
      else
        test_read(12'($urandom), 8'(1 << $urandom_range(0, 7)), $urandom_range(1, 12), 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    int iss, n, d0;
    core_en = 1;
    core_mask = 8'h10;
    rd_ready = 0;
    send_cmd(1, 8'h10, 12'h200, 8'd8);
    iss = 0; n = 0;
    while (iss < 2 && n < 20) begin
      tick();
      n++;
      if (gbus_ren !== 8'h00) iss++;
    end
    checks++;
    if (iss != 2) begin errors++; $display("FAIL rstmid_issue got %0d exp 2", iss); end
    #2 rst = 1;
    #1;
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, busy, done, err, gbus_wen, gbus_ren, gbus_addr, gbus_wdata, rd_data} !== '0)
      begin errors++; $display("FAIL rstmid_outputs got %h exp 0", {cmd_ready, wr_ready, rd_valid, busy, done, err, gbus_wen, gbus_ren, gbus_addr, gbus_wdata, rd_data}); end
    core_en = 0;
    gbus_rvalid = '0;
    due_q.delete();
    dat_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    d0 = done_cnt;
    repeat (6) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_after got dones=%0d busy=%b rd_valid=%b ready=%b exp 0 0 0 1", done_cnt - d0, busy, rd_valid, cmd_ready);
    end
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_core_mask = '0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0; gbus_rdata = '0; gbus_rvalid = '0;
    test_reset();
    test_write(12'h010, 8'h05, 4, 0, 1);
    test_write(12'hFFE, 8'hA1, 3, 1, 0);
    test_read(12'h040, 8'h10, 8, 20, 0);
    test_errors();
    test_spurious();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
